// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues in-order imem requests under a credit scheme,
// buffers returned words with their PCs in a DEPTH-entry FIFO for decode, and
// flushes and restarts on a redirect while discarding stale in-flight responses.
module ifetch_unit #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RST_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_rsp_valid,
  input  logic [DW-1:0] imem_rsp_data,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [AW-1:0] inst_pc,
  output logic [DW-1:0] inst_data
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] pc_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [CW:0]   in_use;
  logic          credit;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic [AW-1:0] redirect_aligned;

  // Handshake qualifiers and the credit check guaranteeing buffer space for every response
  always_comb begin
    in_use           = {1'b0, outstanding} + {1'b0, count};
    credit           = in_use < (CW+1)'(DEPTH);
    redirect_aligned = redirect_pc & ~AW'(3);
    imem_req_valid   = rst_n && credit && !redirect_valid;
    imem_req_addr    = fetch_pc;
    req_fire         = imem_req_valid && imem_req_ready;
    push             = imem_rsp_valid && !redirect_valid && (drop == '0);
    inst_valid       = (count != '0) && !redirect_valid;
    pop              = inst_valid && inst_ready;
    inst_pc          = pc_mem[rd_ptr];
    inst_data        = data_mem[rd_ptr];
  end

  // Fetch PC, response PC, in-flight/drop counters and FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RST_ADDR;
      rsp_pc      <= RST_ADDR;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_aligned;
      rsp_pc      <= redirect_aligned;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      // Every response still in flight is stale now, including any already
      // marked for dropping by an earlier redirect, so drop tracks outstanding.
      drop        <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + AW'(4);
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
      if (push) begin
        rsp_pc <= rsp_pc + AW'(4);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Buffer storage; cleared on reset so the head reads zero while empty after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]   <= rsp_pc;
      data_mem[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule
